sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Time-slot scheduler and arbiter in front of the 16-bit SRAM sequencer. Generates the slot strobes (cyc, c0..c3),
//  picks one of NREQ requesters per slot (requester 0 = video, fixed top priority; 1..NREQ-1 round-robin),
//  drives the sequencer's request bus and returns read data to the winner. Sits between the video/CPU/DMA/TS
//  fetch engines and the SRAM sequencer.
// PARAMETERS
//  NREQ      4   number of requesters (>=2); index 0 is the priority port
//  SLOT_LEN  8   clocks per slot; must be >=8 and a multiple of 4 (covers the sequencer's worst-case read/write path)
//  ADDR_W    21  word address width
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  rq_req      in   NREQ       per-requester request, held until its rq_ack pulse
//  rq_rnw      in   NREQ       1 = read, 0 = write
//  rq_addr     in   NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  rq_wrdata   in   NREQ*16    packed write data
//  rq_bsel     in   NREQ*2     packed byte selects ([0]=low byte, [1]=high byte)
//  rq_ack      out  NREQ       one-hot 1-cycle pulse: request accepted this slot
//  rq_rvalid   out  NREQ       one-hot 1-cycle pulse: rdata valid for that requester
//  rdata       out  16         read data, shared by all requesters
//  cyc         out  1          slot start strobe to sequencer
//  c0,c1,c2,c3 out  1          phase strobes within slot
//  sram_req    out  1          request valid for this slot
//  sram_rnw    out  1          read/~write to sequencer
//  sram_addr   out  ADDR_W     address to sequencer
//  sram_wrdata out  16         write data to sequencer
//  sram_bsel   out  2          byte select to sequencer
//  sram_do     in   16         read data from sequencer
// BEHAVIOUR
//  Reset: phase counter=0, RR pointer=1, all outputs 0 (cyc, c0..c3, rq_ack, rq_rvalid, sram_req, rdata, bus=0).
//  Phase counter 0..SLOT_LEN-1, wraps. cyc and c0 high at phase 0; c1/c2/c3 at phase SLOT_LEN/4, /2, 3*SLOT_LEN/4.
//  All strobes registered; cyc first asserts on the first phase-0 after reset release.
//  Arbitration evaluated combinationally at phase SLOT_LEN-1, registered into bus at phase 0 (same cycle as cyc):
//   - rq_req[0] wins if set; else first set requester scanning from RR pointer upward, wrapping NREQ-1 -> 1.
//   - RR pointer moves to winner+1 (wrapping to 1) only when an RR requester wins; unchanged on video win/idle.
//   - Worst-case wait for RR requester i while video idle: NREQ-2 slots.
//  rq_ack[winner] pulses at phase 0; requester may change inputs from phase 1 on.
//  No requester: cyc still pulses, sram_req=0, bus holds previous values.
//  Write with bsel==2'b00: acked, but sram_req=0 (sequencer would otherwise write the addressed byte).
//  bsel on reads forced to 2'b11 on sram_bsel.
//  Read: winner index and read flag stored; at phase 0 of the next slot rdata<=sram_do and rq_rvalid[idx] pulses
//   next cycle (phase 1). Latency cyc -> rq_rvalid = SLOT_LEN+1 clocks; rdata holds until next read return.
//  Back-to-back reads by same requester in consecutive slots are legal; ack of slot n+1 and rvalid of slot n
//   are one cycle apart.
//  Requester dropping rq_req before ack: no grant, no side effect. Sampling only at phase SLOT_LEN-1.
//  rst_n assertion mid-slot: all state cleared immediately; pending rvalid lost; requesters must re-request.
// STRUCTURE
//  Shared include (tune.v-level): requester index constants (RQ_VID=0, RQ_CPU=1, RQ_DMA=2, RQ_TS=3), SLOT_LEN default.
//  One sub-module: rr_pick (NREQ-1 wide request + pointer -> one-hot grant, valid, next pointer; combinational).
//  Top: phase counter, strobe regs, mux of packed inputs by winner, read-return tracker.
// TESTING
//  Reset release, no requests -> cyc/c0 every 8 clocks, c1/c2/c3 at phases 2/4/6, sram_req=0 throughout.
//  Video + CPU both request reads every slot -> video acked every slot, CPU never; CPU acked first slot video drops.
//  Req 1,2,3 held continuously, video idle -> ack order 1,2,3,1,2,3; pointer wrap 3->1 verified.
//  Read from req 2 addr 0x12345, model returns 0xBEEF -> rq_rvalid[2] 9 clocks after cyc, rdata=0xBEEF.
//  Write req 1 bsel=2'b00 -> rq_ack[1] pulses, sram_req=0; bsel=2'b10 data 0xA55A -> sram_bsel=10, sram_wrdata=0xA55A.
//  Assert rst_n low at phase 3 of a pending read -> all outputs 0 at once, no rq_rvalid after release.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: requester ids and default geometry shared by the arbiter files
package sram_arbiter_pkg;
    typedef enum logic [1:0] {RQ_VID = 2'd0, RQ_CPU = 2'd1, RQ_DMA = 2'd2, RQ_TS = 2'd3} rq_id_e;
    localparam int NREQ_DEF = 4;
    localparam int SLOT_LEN_DEF = 8;
    localparam int ADDR_W_DEF = 21;
    localparam logic [1:0] BSEL_ALL = 2'b11;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side and sequencer-side signals of the slot arbiter
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [NREQ-1:0] rq_req;
    logic [NREQ-1:0] rq_rnw;
    logic [NREQ*ADDR_W-1:0] rq_addr;
    logic [NREQ*16-1:0] rq_wrdata;
    logic [NREQ*2-1:0] rq_bsel;
    logic [NREQ-1:0] rq_ack;
    logic [NREQ-1:0] rq_rvalid;
    logic [15:0] rdata;
    logic cyc;
    logic c0;
    logic c1;
    logic c2;
    logic c3;
    logic sram_req;
    logic sram_rnw;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0] sram_wrdata;
    logic [1:0] sram_bsel;
    logic [15:0] sram_do;
    modport slave (
        input rq_req, rq_rnw, rq_addr, rq_wrdata, rq_bsel, sram_do,
        output rq_ack, rq_rvalid, rdata, cyc, c0, c1, c2, c3,
        output sram_req, sram_rnw, sram_addr, sram_wrdata, sram_bsel
    );
    modport master (
        output rq_req, rq_rnw, rq_addr, rq_wrdata, rq_bsel, sram_do,
        input rq_ack, rq_rvalid, rdata, cyc, c0, c1, c2, c3,
        input sram_req, sram_rnw, sram_addr, sram_wrdata, sram_bsel
    );
endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// sram_arbiter_rr_pick: round-robin pick among requesters 1..N, pointer holds requester number 1..N
module sram_arbiter_rr_pick #(
    parameter int N = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld,
    output logic [PW-1:0] nxt
);
    int j;
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        nxt = ptr;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) - 1 + k) % N;
            if (!vld && req[j]) begin
                gnt[j] = 1'b1;
                vld = 1'b1;
                nxt = (j == N - 1) ? PW'(1) : PW'(j + 2);
            end
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: slot strobe generator and video-priority / round-robin arbiter in front of the SRAM sequencer
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic clk,
    input logic rst_n,
    sram_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(SLOT_LEN);
    logic [CW-1:0] phase_q, phase_d;
    logic cyc_q, cyc_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [PW-1:0] ptr_q, ptr_d, rr_nxt, win, idx_q, idx_d, rd_idx_q, rd_idx_d;
    logic [NREQ-2:0] rr_gnt;
    logic rr_vld, last, first, any, win_rnw;
    logic [1:0] win_bsel;
    logic [NREQ-1:0] gnt, ack_q, ack_d, rvalid_q, rvalid_d;
    logic req_q, req_d, rnw_q, rnw_d, rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0] wrdata_q, wrdata_d, rdata_q, rdata_d;
    logic [1:0] bsel_q, bsel_d;

    sram_arbiter_rr_pick #(.N(NREQ - 1), .PW(PW)) u_rr_pick (
        .req(bus.rq_req[NREQ-1:1]),
        .ptr(ptr_q),
        .gnt(rr_gnt),
        .vld(rr_vld),
        .nxt(rr_nxt)
    );

    // Grant is decided on the last phase and lands on the bus with the next cyc.
    // Read data returns at phase 0 of the following slot, so the pending read is
    // handed over from the current-slot registers exactly at phase 0.
    always_comb begin
        last = phase_q == CW'(SLOT_LEN - 1);
        first = phase_q == '0;
        phase_d = last ? '0 : phase_q + 1'b1;
        cyc_d = phase_d == '0;
        c1_d = phase_d == CW'(SLOT_LEN / 4);
        c2_d = phase_d == CW'(SLOT_LEN / 2);
        c3_d = phase_d == CW'(3 * SLOT_LEN / 4);
        gnt = bus.rq_req[RQ_VID] ? NREQ'(1) : {rr_gnt, 1'b0};
        any = |gnt;
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) win = PW'(i);
        win_rnw = bus.rq_rnw[win];
        win_bsel = bus.rq_bsel[win*2 +: 2];
        ptr_d = (last && !bus.rq_req[RQ_VID] && rr_vld) ? rr_nxt : ptr_q;
        ack_d = last ? gnt : '0;
        req_d = last ? (any && (win_rnw || win_bsel != 2'b00)) : req_q;
        rnw_d = (last && any) ? win_rnw : rnw_q;
        addr_d = (last && any) ? bus.rq_addr[win*ADDR_W +: ADDR_W] : addr_q;
        wrdata_d = (last && any) ? bus.rq_wrdata[win*16 +: 16] : wrdata_q;
        bsel_d = (last && any) ? (win_rnw ? BSEL_ALL : win_bsel) : bsel_q;
        idx_d = (last && any) ? win : idx_q;
        rvalid_d = (first && rd_pend_q) ? NREQ'(1) << rd_idx_q : '0;
        rdata_d = (first && rd_pend_q) ? bus.sram_do : rdata_q;
        rd_pend_d = first ? (req_q && rnw_q) : rd_pend_q;
        rd_idx_d = first ? idx_q : rd_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            cyc_q <= 1'b0;
            c1_q <= 1'b0;
            c2_q <= 1'b0;
            c3_q <= 1'b0;
            ptr_q <= PW'(1);
            ack_q <= '0;
            req_q <= 1'b0;
            rnw_q <= 1'b0;
            addr_q <= '0;
            wrdata_q <= '0;
            bsel_q <= '0;
            idx_q <= '0;
            rvalid_q <= '0;
            rdata_q <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            phase_q <= phase_d;
            cyc_q <= cyc_d;
            c1_q <= c1_d;
            c2_q <= c2_d;
            c3_q <= c3_d;
            ptr_q <= ptr_d;
            ack_q <= ack_d;
            req_q <= req_d;
            rnw_q <= rnw_d;
            addr_q <= addr_d;
            wrdata_q <= wrdata_d;
            bsel_q <= bsel_d;
            idx_q <= idx_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign bus.cyc = cyc_q;
    assign bus.c0 = cyc_q;
    assign bus.c1 = c1_q;
    assign bus.c2 = c2_q;
    assign bus.c3 = c3_q;
    assign bus.rq_ack = ack_q;
    assign bus.rq_rvalid = rvalid_q;
    assign bus.rdata = rdata_q;
    assign bus.sram_req = req_q;
    assign bus.sram_rnw = rnw_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_wrdata = wrdata_q;
    assign bus.sram_bsel = bsel_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed steps with a read-return scoreboard against a simple sequencer model
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;
    localparam int NREQ = 4;
    localparam int SLOT_LEN = 8;
    localparam int ADDR_W = 21;
    typedef struct {int idx; logic [15:0] data; int due;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [15:0] seq_do = '0;
    exp_t sb[$];
    exp_t e;
    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    logic [NREQ*ADDR_W-1:0] snap_addr;
    logic [NREQ-1:0] snap_rnw;

    always #5 clk = ~clk;

    sram_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

    sram_arbiter #(.NREQ(NREQ), .SLOT_LEN(SLOT_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.sram_do = seq_do;

    function automatic logic [15:0] mem_rd(input logic [ADDR_W-1:0] a);
        return (a == 21'h12345) ? 16'hBEEF : a[15:0] ^ 16'hC3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sequencer model: read issued at cyc, data presented from the next clock on.
    always @(posedge clk)
        if (bus.cyc && bus.sram_req && bus.sram_rnw) seq_do <= mem_rd(bus.sram_addr);

    always @(posedge clk) begin
        cyc_cnt++;
        snap_addr = bus.rq_addr;
        snap_rnw = bus.rq_rnw;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (bus.rq_ack[i] && snap_rnw[i])
                sb.push_back('{i, mem_rd(snap_addr[i*ADDR_W +: ADDR_W]), cyc_cnt + SLOT_LEN + 1});
        if (bus.rq_rvalid != '0) begin
            if (sb.size() == 0) chk("rvalid_unexpected", 32'(bus.rq_rvalid), 0);
            else begin
                e = sb.pop_front();
                chk("rvalid_idx", 32'(bus.rq_rvalid), 32'(1) << e.idx);
                chk("rvalid_data", 32'(bus.rdata), 32'(e.data));
                chk("rvalid_latency", cyc_cnt, e.due);
            end
        end else if (sb.size() > 0 && cyc_cnt > sb[0].due) begin
            chk("rvalid_missing", cyc_cnt, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic req, input logic rnw, input logic [ADDR_W-1:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        bus.rq_req[i] = req;
        bus.rq_rnw[i] = rnw;
        bus.rq_addr[i*ADDR_W +: ADDR_W] = a;
        bus.rq_wrdata[i*16 +: 16] = d;
        bus.rq_bsel[i*2 +: 2] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rq_req = '0;
        bus.rq_rnw = '0;
        bus.rq_addr = '0;
        bus.rq_wrdata = '0;
        bus.rq_bsel = '0;
        sb.delete();
        #1;
        chk("rst_ctrl", 32'({bus.cyc, bus.c0, bus.c1, bus.c2, bus.c3, bus.sram_req, bus.sram_rnw,
                             bus.sram_bsel, bus.rq_ack, bus.rq_rvalid}), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_addr", 32'(bus.sram_addr), 0);
        chk("rst_wrdata", 32'(bus.sram_wrdata), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_cyc();
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.cyc && n < 2 * SLOT_LEN);
        chk("cyc_seen", 32'(bus.cyc), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[6] = '{1, 2, 3, 1, 2, 3};
        int lat;
        logic seen;
        #2;
        do_reset();
        for (int k = 1; k <= 3 * SLOT_LEN; k++) begin
            step();
            chk("idle_strobes", 32'({bus.cyc, bus.c0, bus.c1, bus.c2, bus.c3, bus.sram_req}),
                32'({k % 8 == 0, k % 8 == 0, k % 8 == 2, k % 8 == 4, k % 8 == 6, 1'b0}));
        end

        do_reset();
        set_rq(0, 1'b1, 1'b1, 21'h00100, 16'h0, 2'b11);
        set_rq(1, 1'b1, 1'b1, 21'h00200, 16'h0, 2'b11);
        for (int s = 0; s < 3; s++) begin
            wait_cyc();
            chk("vid_prio_ack", 32'(bus.rq_ack), 32'h1);
            bus.rq_addr[0 +: ADDR_W] = 21'h00101 + 21'(s);
        end
        bus.rq_req[0] = 1'b0;
        wait_cyc();
        chk("cpu_after_vid_ack", 32'(bus.rq_ack), 32'h2);
        chk("cpu_after_vid_addr", 32'(bus.sram_addr), 32'h200);
        bus.rq_req[1] = 1'b0;
        wait_cyc();
        chk("idle_ack", 32'(bus.rq_ack), 0);
        chk("idle_req", 32'(bus.sram_req), 0);
        chk("idle_bus_hold", 32'(bus.sram_addr), 32'h200);
        repeat (3) step();
        chk("sb_drain_vid", sb.size(), 0);

        do_reset();
        for (int i = 1; i < NREQ; i++)
            set_rq(i, 1'b1, 1'b0, ADDR_W'(32'h1000 * i), 16'(32'h1111 * i), 2'b11);
        for (int s = 0; s < 6; s++) begin
            wait_cyc();
            chk("rr_ack", 32'(bus.rq_ack), 32'(1) << order[s]);
            chk("rr_addr", 32'(bus.sram_addr), 32'h1000 * order[s]);
        end
        bus.rq_req = '0;

        do_reset();
        set_rq(2, 1'b1, 1'b1, 21'h12345, 16'h0, 2'b01);
        wait_cyc();
        chk("rd_ack", 32'(bus.rq_ack), 32'h4);
        chk("rd_bus", 32'({bus.sram_req, bus.sram_rnw, bus.sram_bsel}), 32'b1111);
        chk("rd_addr", 32'(bus.sram_addr), 32'h12345);
        bus.rq_req[2] = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus.rq_rvalid[2] && lat < 3 * SLOT_LEN);
        chk("rd_latency", lat, SLOT_LEN + 1);
        chk("rd_data", 32'(bus.rdata), 32'hBEEF);
        repeat (4) step();
        chk("rd_data_hold", 32'(bus.rdata), 32'hBEEF);

        do_reset();
        set_rq(1, 1'b1, 1'b0, 21'h00555, 16'h1234, 2'b00);
        wait_cyc();
        chk("wr_nobsel_ack", 32'(bus.rq_ack), 32'h2);
        chk("wr_nobsel_req", 32'(bus.sram_req), 0);
        set_rq(1, 1'b1, 1'b0, 21'h00556, 16'hA55A, 2'b10);
        wait_cyc();
        chk("wr_ack", 32'(bus.rq_ack), 32'h2);
        chk("wr_bus", 32'({bus.sram_req, bus.sram_rnw, bus.sram_bsel}), 32'b1010);
        chk("wr_data", 32'(bus.sram_wrdata), 32'hA55A);
        chk("wr_addr", 32'(bus.sram_addr), 32'h556);
        bus.rq_req = '0;

        do_reset();
        set_rq(3, 1'b1, 1'b1, 21'h00777, 16'h0, 2'b11);
        wait_cyc();
        chk("rst_rd_ack", 32'(bus.rq_ack), 32'h8);
        bus.rq_req = '0;
        repeat (3) step();
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 3 * SLOT_LEN; k++) begin
            step();
            seen = seen | (|bus.rq_rvalid);
        end
        chk("no_rvalid_after_rst", 32'(seen), 0);
        repeat (2) step();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
